// File: rtl/serializador_pixel_if.sv
// Pixel-in and byte-out valid/ready streams of the pixel serializer.
// master drives pixels and byte_ready; slave is the serializer.
interface serializador_pixel_if;
  logic [15:0] pixel_in;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;

  modport master (
    output pixel_in,
    output pixel_valid,
    output byte_ready,
    input  pixel_ready,
    input  byte_out,
    input  byte_valid
  );

  modport slave (
    input  pixel_in,
    input  pixel_valid,
    input  byte_ready,
    output pixel_ready,
    output byte_out,
    output byte_valid
  );
endinterface

// File: rtl/serializador_pixel.sv
// Splits RGB565 pixels into high/low bytes for the serial transmitter and
// counts pixels per frame, pulsing done after the last byte is accepted.
module serializador_pixel #(
  parameter int unsigned PIXELS_PER_FRAME = 19200,
  parameter int unsigned COUNT_WIDTH      = 15
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic                   start,
  serializador_pixel_if.slave    stream,
  output logic [COUNT_WIDTH-1:0] pixel_count,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitPixel,
    StSendHigh,
    StSendLow,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [15:0]            latch_q, latch_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   last_pixel;

  assign count_inc  = count_q + 1'b1;
  assign last_pixel = (count_inc == COUNT_WIDTH'(PIXELS_PER_FRAME));

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= StIdle;
      latch_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    latch_d            = latch_q;
    count_d            = count_q;
    stream.pixel_ready = 1'b0;
    stream.byte_valid  = 1'b0;
    stream.byte_out    = 8'h00;
    done               = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d = '0;
          state_d = StWaitPixel;
        end
      end
      StWaitPixel: begin
        stream.pixel_ready = 1'b1;
        if (stream.pixel_valid) begin
          latch_d = stream.pixel_in;
          state_d = StSendHigh;
        end
      end
      StSendHigh: begin
        stream.byte_valid = 1'b1;
        stream.byte_out   = latch_q[15:8];
        if (stream.byte_ready) state_d = StSendLow;
      end
      StSendLow: begin
        stream.byte_valid = 1'b1;
        stream.byte_out   = latch_q[7:0];
        // Back-to-back accept, suppressed on the frame's last pixel.
        stream.pixel_ready = stream.byte_ready & ~last_pixel;
        if (stream.byte_ready) begin
          count_d = count_inc;
          if (last_pixel) begin
            state_d = StDone;
          end else if (stream.pixel_valid) begin
            latch_d = stream.pixel_in;
            state_d = StSendHigh;
          end else begin
            state_d = StWaitPixel;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign pixel_count = count_q;

endmodule

// File: tb/tb_serializador_pixel.sv
// Directed bench for serializador_pixel: one-pixel and four-pixel frames,
// backpressure, starvation, ignored start and mid-frame reset.
module tb_serializador_pixel;

  logic        clock;
  logic        clear_n;
  logic        start1, start4;
  logic [14:0] cnt1, cnt4;
  logic        busy1, busy4, done1, done4;

  int vectors;
  int miscompares;

  serializador_pixel_if if1 ();
  serializador_pixel_if if4 ();

  serializador_pixel #(
    .PIXELS_PER_FRAME(1),
    .COUNT_WIDTH     (15)
  ) dut1 (
    .clock      (clock),
    .clear_n    (clear_n),
    .start      (start1),
    .stream     (if1.slave),
    .pixel_count(cnt1),
    .busy       (busy1),
    .done       (done1)
  );

  serializador_pixel #(
    .PIXELS_PER_FRAME(4),
    .COUNT_WIDTH     (15)
  ) dut4 (
    .clock      (clock),
    .clear_n    (clear_n),
    .start      (start4),
    .stream     (if4.slave),
    .pixel_count(cnt4),
    .busy       (busy4),
    .done       (done4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [15:0] px [4];

  initial begin
    vectors         = 0;
    miscompares     = 0;
    px              = '{16'hF00F, 16'h1234, 16'hABCD, 16'h00FF};
    clear_n         = 1'b0;
    start1          = 1'b0;
    start4          = 1'b0;
    if1.pixel_in    = 16'h0;
    if1.pixel_valid = 1'b0;
    if1.byte_ready  = 1'b0;
    if4.pixel_in    = 16'h0;
    if4.pixel_valid = 1'b0;
    if4.byte_ready  = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_byte_valid", 32'(if4.byte_valid), 32'd0);
    chk("rst_pixel_ready", 32'(if4.pixel_ready), 32'd0);
    chk("rst_byte_out", 32'(if4.byte_out), 32'h00);
    chk("rst_count", 32'(cnt4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    clear_n = 1'b1;
    step();

    // Single pixel frame
    start1 = 1'b1;
    step();
    start1          = 1'b0;
    if1.pixel_in    = 16'hAACC;
    if1.pixel_valid = 1'b1;
    if1.byte_ready  = 1'b1;
    #1;
    chk("p1_wait_ready", 32'(if1.pixel_ready), 32'd1);
    chk("p1_wait_busy", 32'(busy1), 32'd1);
    chk("p1_wait_bvalid", 32'(if1.byte_valid), 32'd0);
    step();
    if1.pixel_valid = 1'b0;
    #1;
    chk("p1_high_byte", 32'(if1.byte_out), 32'hAA);
    chk("p1_high_valid", 32'(if1.byte_valid), 32'd1);
    chk("p1_high_pready", 32'(if1.pixel_ready), 32'd0);
    step();
    if1.pixel_valid = 1'b1;
    #1;
    chk("p1_low_byte", 32'(if1.byte_out), 32'hCC);
    chk("p1_low_pready", 32'(if1.pixel_ready), 32'd0);
    step();
    chk("p1_done", 32'(done1), 32'd1);
    chk("p1_done_busy", 32'(busy1), 32'd1);
    chk("p1_done_count", 32'(cnt1), 32'd1);
    chk("p1_done_bvalid", 32'(if1.byte_valid), 32'd0);
    step();
    if1.pixel_valid = 1'b0;
    chk("p1_idle_done", 32'(done1), 32'd0);
    chk("p1_idle_busy", 32'(busy1), 32'd0);
    chk("p1_idle_count", 32'(cnt1), 32'd1);

    // Back-to-back four-pixel frame
    if4.byte_ready = 1'b1;
    start4         = 1'b1;
    step();
    start4          = 1'b0;
    if4.pixel_in    = px[0];
    if4.pixel_valid = 1'b1;
    #1;
    chk("b2b_wait_ready", 32'(if4.pixel_ready), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      if4.pixel_in = 16'h5A5A;
      #1;
      chk("b2b_high_byte", 32'(if4.byte_out), 32'(px[i][15:8]));
      chk("b2b_high_valid", 32'(if4.byte_valid), 32'd1);
      chk("b2b_high_pready", 32'(if4.pixel_ready), 32'd0);
      chk("b2b_high_count", 32'(cnt4), 32'(i));
      step();
      if4.pixel_in = (i < 3) ? px[i+1] : 16'h7777;
      #1;
      chk("b2b_low_byte", 32'(if4.byte_out), 32'(px[i][7:0]));
      chk("b2b_low_pready", 32'(if4.pixel_ready), (i < 3) ? 32'd1 : 32'd0);
      step();
    end
    chk("b2b_done", 32'(done4), 32'd1);
    chk("b2b_done_count", 32'(cnt4), 32'd4);
    chk("b2b_done_bvalid", 32'(if4.byte_valid), 32'd0);
    step();
    chk("b2b_idle_pready", 32'(if4.pixel_ready), 32'd0);
    chk("b2b_idle_busy", 32'(busy4), 32'd0);
    chk("b2b_idle_count", 32'(cnt4), 32'd4);
    if4.pixel_valid = 1'b0;

    // Backpressure on the high byte of CC33
    start4 = 1'b1;
    step();
    start4          = 1'b0;
    if4.pixel_in    = 16'hCC33;
    if4.pixel_valid = 1'b1;
    if4.byte_ready  = 1'b0;
    #1;
    chk("bp_count_cleared", 32'(cnt4), 32'd0);
    step();
    if4.pixel_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_stall_byte", 32'(if4.byte_out), 32'hCC);
      chk("bp_stall_valid", 32'(if4.byte_valid), 32'd1);
      chk("bp_stall_pready", 32'(if4.pixel_ready), 32'd0);
      step();
    end
    if4.byte_ready = 1'b1;
    #1;
    chk("bp_release_byte", 32'(if4.byte_out), 32'hCC);
    step();
    chk("bp_low_byte", 32'(if4.byte_out), 32'h33);
    chk("bp_low_pready", 32'(if4.pixel_ready), 32'd1);
    step();

    // Source starvation
    for (int k = 0; k < 3; k++) begin
      chk("starve_bvalid", 32'(if4.byte_valid), 32'd0);
      chk("starve_pready", 32'(if4.pixel_ready), 32'd1);
      chk("starve_count", 32'(cnt4), 32'd1);
      step();
    end
    if4.pixel_in    = 16'h1111;
    if4.pixel_valid = 1'b1;
    step();
    if4.pixel_valid = 1'b0;
    #1;
    chk("starve_high_byte", 32'(if4.byte_out), 32'h11);
    step();

    // Start ignored while busy
    start4          = 1'b1;
    if4.pixel_in    = 16'h2222;
    if4.pixel_valid = 1'b1;
    #1;
    chk("ign_low_byte", 32'(if4.byte_out), 32'h11);
    chk("ign_low_count", 32'(cnt4), 32'd1);
    step();
    start4 = 1'b0;
    chk("ign_count_kept", 32'(cnt4), 32'd2);
    chk("ign_high_byte", 32'(if4.byte_out), 32'h22);
    step();
    if4.pixel_in = 16'h3333;
    step();
    chk("ign_p3_high", 32'(if4.byte_out), 32'h33);
    chk("ign_p3_count", 32'(cnt4), 32'd3);
    step();
    chk("ign_last_pready", 32'(if4.pixel_ready), 32'd0);
    step();
    start4 = 1'b1;
    #1;
    chk("ign_done", 32'(done4), 32'd1);
    chk("ign_done_count", 32'(cnt4), 32'd4);
    step();
    if4.pixel_valid = 1'b0;
    chk("ign_idle_busy", 32'(busy4), 32'd0);
    chk("ign_idle_done", 32'(done4), 32'd0);
    chk("ign_idle_count", 32'(cnt4), 32'd4);
    step();
    start4 = 1'b0;
    chk("restart_busy", 32'(busy4), 32'd1);
    chk("restart_count", 32'(cnt4), 32'd0);

    // Reset mid SEND_HIGH with AACC latched
    if4.pixel_in    = 16'h0102;
    if4.pixel_valid = 1'b1;
    step();
    if4.pixel_in = 16'hAACC;
    step();
    step();
    if4.pixel_valid = 1'b0;
    if4.byte_ready  = 1'b0;
    #1;
    chk("mr_high_byte", 32'(if4.byte_out), 32'hAA);
    chk("mr_count_before", 32'(cnt4), 32'd1);
    clear_n = 1'b0;
    #1;
    chk("mr_bvalid", 32'(if4.byte_valid), 32'd0);
    chk("mr_byte_out", 32'(if4.byte_out), 32'h00);
    chk("mr_count", 32'(cnt4), 32'd0);
    chk("mr_busy", 32'(busy4), 32'd0);
    step();
    clear_n         = 1'b1;
    if4.byte_ready  = 1'b1;
    if4.pixel_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mr_after_bvalid", 32'(if4.byte_valid), 32'd0);
      chk("mr_after_pready", 32'(if4.pixel_ready), 32'd0);
      chk("mr_after_busy", 32'(busy4), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serializador_pixel.md
Name: serializador_pixel

Overview:
- Transmit-side counterpart of the pixel assembly register.
- Accepts 16-bit RGB565 pixels over a valid/ready handshake and emits each one as two bytes, high byte first, over a byte valid/ready handshake toward the serial/UART transmitter.
- Counts pixels per frame, raises done after the last byte of the frame, and sustains 2 cycles/pixel when both sides are always ready.

Parameters:
- PIXELS_PER_FRAME, 19200, number of pixels in one frame (160x120).
- COUNT_WIDTH, 15, width of pixel counter; must satisfy 2^COUNT_WIDTH > PIXELS_PER_FRAME.

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a frame when idle, ignored otherwise.
- pixel_in  in  16  pixel data, [15:8] = high byte.
- pixel_valid  in  1  pixel_in is valid.
- pixel_ready  out  1  block accepts pixel this cycle.
- byte_out  out  8  byte to transmitter.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  transmitter accepts byte_out this cycle.
- pixel_count  out  COUNT_WIDTH  pixels fully sent in current frame.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse after last byte of frame accepted.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - State IDLE.
  - All outputs 0: byte_out=8'h00, byte_valid=0, pixel_ready=0, pixel_count=0, busy=0, done=0.
  - Internal pixel latch cleared.
- Transfer rules:
  - A pixel transfer occurs on a rising edge with pixel_valid&pixel_ready.
  - A byte transfer occurs on a rising edge with byte_valid&byte_ready.
- FSM states:
  - IDLE: pixel_ready=0, byte_valid=0. On start: pixel_count<=0, busy<=1, go WAIT_PIXEL.
  - WAIT_PIXEL: pixel_ready=1, byte_valid=0. On pixel transfer: latch pixel_in, go SEND_HIGH.
  - SEND_HIGH: byte_valid=1, byte_out=latch[15:8], pixel_ready=0. On byte transfer go SEND_LOW; otherwise hold byte_out stable.
  - SEND_LOW: byte_valid=1, byte_out=latch[7:0]. On byte transfer, pixel_count increments. Then:
    - If pixel_count+1 == PIXELS_PER_FRAME: go DONE.
    - Else if pixel_valid is also high in that cycle: that pixel is accepted (back-to-back) and latched, go SEND_HIGH.
    - Else go WAIT_PIXEL.
  - SEND_LOW pixel_ready = byte_ready & (pixel_count+1 != PIXELS_PER_FRAME). This is the only combinational path from an input to an output.
  - DONE: done=1 for exactly one cycle, busy<=0, go IDLE. pixel_count holds its final value until the next start.
- Latency and throughput:
  - High byte is presented the cycle after pixel acceptance; low byte the cycle after high-byte acceptance.
  - Steady state: one pixel per 2 cycles.
- Stability: byte_out and byte_valid must not change while byte_valid=1 and byte_ready=0. The transmitter may stall indefinitely.
- Frame boundary: the last pixel is never followed by an extra pixel accept; pixel_ready=0 in SEND_LOW of the last pixel.
- Ignored inputs:
  - start is ignored outside IDLE.
  - pixel_valid is ignored in IDLE, SEND_HIGH, DONE.
  - start during DONE is ignored; start is accepted on the following IDLE cycle.
- Reset mid-frame: immediate return to IDLE with all outputs zero; a partial pixel is discarded. No byte is emitted after reset until a new start.
- PIXELS_PER_FRAME=1 must work: start -> one pixel -> two bytes -> done.

Test Plan:
- Reset: clear_n=0 mid-SEND_HIGH with pixel 16'hAACC latched -> same cycle byte_valid=0, pixel_count=0, busy=0; after release, no byte until start.
- Single pixel (PIXELS_PER_FRAME=1), byte_ready=1: start, pixel 16'hAACC -> byte_out 8'hAA then 8'hCC on consecutive cycles; done pulses 1 cycle; pixel_count=1; busy falls.
- Back-to-back, PIXELS_PER_FRAME=4, both sides always ready: pixels F00F,1234,ABCD,00FF -> bytes F0,0F,12,34,AB,CD,00,FF in 8 consecutive cycles; no extra pixel accepted; done after 8th byte.
- Backpressure: byte_ready=0 for 5 cycles during SEND_HIGH of 16'hCC33 -> byte_out stays 8'hCC with byte_valid=1; pixel_ready=0 throughout; then 8'h33 follows.
- Source starvation: pixel_valid=0 for 3 cycles between pixels -> byte_valid=0 and pixel_ready=1 while waiting; pixel_count unchanged.
- Start ignored while busy: start pulsed during SEND_LOW -> pixel_count not cleared; frame completes normally; second start after done begins a new frame with pixel_count=0.
